// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM states,
// load-stream framing constants and the word address helper.
package imem_loader_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LEN_LO,
      LEN_HI,
      DATA,
      CHECK,
      DONE,
      ERR
   } state_t;

   localparam int unsigned HDR_BYTES      = 2;
   localparam int unsigned BYTES_PER_WORD = 4;

   function automatic logic [31:0] word_addr(input logic [31:0] base,
                                             input logic [15:0] count);
      return base + 32'(count) * 32'(BYTES_PER_WORD);
   endfunction

endpackage

// File: rtl/imem_loader.sv
// Byte-stream instruction-memory loader: parses LEN/payload/CHK frames,
// writes assembled words and holds the CPU in reset until a good load.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = 256,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        byte_valid,
   input  logic [7:0]  byte_data,
   output logic        byte_ready,
   output logic        imem_we,
   output logic [31:0] imem_addr,
   output logic [31:0] imem_wdata,
   output logic        cpu_reset,
   output logic        load_done,
   output logic        error,
   output logic [15:0] word_count
);

   state_t                 state, state_nx;
   logic [8*HDR_BYTES-1:0] len;
   logic [15:0]            wcnt;
   logic [1:0]             bidx;
   logic [7:0]             chk;
   logic [31:0]            wdata;
   logic                   we;
   logic                   accept;
   logic                   restart;
   logic [15:0]            len_n;

   assign accept  = byte_valid && byte_ready;
   assign restart = start && (state == IDLE || state == DONE || state == ERR);
   assign len_n   = {byte_data, len[7:0]};

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE, DONE, ERR: if (start) state_nx = LEN_LO;
         LEN_LO:          if (accept) state_nx = LEN_HI;
         LEN_HI: begin
            if (accept) begin
               if (32'(len_n) > DEPTH_WORDS) state_nx = ERR;
               else if (len_n == 16'd0)      state_nx = CHECK;
               else                          state_nx = DATA;
            end
         end
         // Leave DATA on the write cycle of the final word, not on its last byte.
         DATA:   if (we && (wcnt + 16'd1) == len) state_nx = CHECK;
         CHECK:  if (accept) state_nx = (byte_data == chk) ? DONE : ERR;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      byte_ready = 1'b0;
      cpu_reset  = 1'b1;
      load_done  = 1'b0;
      error      = 1'b0;
      unique case (state)
         LEN_LO, LEN_HI, DATA, CHECK: byte_ready = !we;
         DONE: begin
            cpu_reset = 1'b0;
            load_done = 1'b1;
         end
         ERR:     error = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         len   <= '0;
         wcnt  <= '0;
         bidx  <= '0;
         chk   <= '0;
         wdata <= '0;
         we    <= 1'b0;
      end else begin
         we <= 1'b0;
         if (restart) begin
            wcnt <= '0;
            bidx <= '0;
            chk  <= '0;
         end
         if (accept) begin
            unique case (state)
               LEN_LO: len[7:0] <= byte_data;
               LEN_HI: len[8*HDR_BYTES-1:8] <= byte_data;
               DATA: begin
                  wdata[{bidx, 3'b000} +: 8] <= byte_data;
                  chk  <= chk ^ byte_data;
                  bidx <= bidx + 2'd1;
                  if (bidx == 2'(BYTES_PER_WORD - 1)) we <= 1'b1;
               end
               default: ;
            endcase
         end
         if (we) wcnt <= wcnt + 16'd1;
      end
   end

   assign imem_we    = we;
   assign imem_wdata = wdata;
   assign imem_addr  = word_addr(BASE_ADDR, wcnt);
   assign word_count = wcnt;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized scoreboard bench for imem_loader: a frame-level model queues the
// expected memory writes and final status; a monitor checks DUT outputs.
module tb_imem_loader;

   localparam int unsigned DEPTH = 256;
   localparam logic [31:0] BASE  = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        reset, start, byte_valid;
   logic [7:0]  byte_data;
   logic        byte_ready, imem_we, cpu_reset, load_done, error;
   logic [31:0] imem_addr, imem_wdata;
   logic [15:0] word_count;

   imem_loader #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE)) dut (
      .clk(clk), .reset(reset), .start(start),
      .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
      .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
      .cpu_reset(cpu_reset), .load_done(load_done), .error(error),
      .word_count(word_count)
   );

   always #5 clk = ~clk;

   typedef struct { logic [31:0] addr; logic [31:0] data; } wr_t;
   typedef struct { logic done; logic err; logic cpur; logic [15:0] wc; } st_t;

   wr_t         exp_wr[$];
   st_t         exp_st[$];
   logic [31:0] ld_words[$];
   int          total  = 0;
   int          passes = 0;
   logic        prev_end = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // Monitor: every write and every arrival in DONE/ERR is matched against the model.
   always @(negedge clk) begin
      if (reset) prev_end = 1'b0;
      else begin
         if (imem_we) begin
            check("ready_during_write", {31'b0, byte_ready}, 32'd0);
            if (exp_wr.size() == 0) check("unexpected_write", imem_addr, 32'hFFFF_FFFF);
            else begin
               wr_t w;
               w = exp_wr.pop_front();
               check("write_addr", imem_addr, w.addr);
               check("write_data", imem_wdata, w.data);
            end
         end
         if ((load_done || error) && !prev_end) begin
            if (exp_st.size() == 0) check("unexpected_end", {30'b0, load_done, error}, 32'd0);
            else begin
               st_t s;
               s = exp_st.pop_front();
               check("load_done", {31'b0, load_done}, {31'b0, s.done});
               check("error", {31'b0, error}, {31'b0, s.err});
               check("cpu_reset", {31'b0, cpu_reset}, {31'b0, s.cpur});
               check("word_count", {16'b0, word_count}, {16'b0, s.wc});
               check("ready_at_end", {31'b0, byte_ready}, 32'd0);
            end
         end
         prev_end = load_done || error;
      end
   end

   task automatic send_byte(input logic [7:0] b, input int gap, input bit poke);
      int t;
      for (int i = 0; i < gap; i++) begin
         @(negedge clk);
         byte_valid = 1'b0;
         start      = poke && (i == 0);
      end
      t = 0;
      forever begin
         @(negedge clk);
         start      = 1'b0;
         byte_valid = 1'b1;
         byte_data  = b;
         if (byte_ready) break;
         t++;
         if (t > 50) begin
            total++;
            $display("FAIL byte_timeout: byte_ready stayed 0 expected 1");
            break;
         end
      end
   endtask

   task automatic do_start();
      @(negedge clk);
      byte_valid = 1'b0;
      start      = 1'b1;
      @(negedge clk);
      start      = 1'b0;
   endtask

   task automatic drain();
      for (int t = 0; t < 400 && (exp_st.size() != 0 || exp_wr.size() != 0); t++)
         @(negedge clk);
      check("scoreboard_drained", exp_st.size() + exp_wr.size(), 32'd0);
   endtask

   // Reference model works on whole frames; driver then streams the bytes.
   task automatic run_load(input logic [15:0] n, input logic [7:0] chk_flip,
                           input int max_gap, input bit poke);
      logic [7:0] x;
      st_t        s;
      x = 8'h00;
      if (32'(n) > DEPTH) begin
         s = '{done: 1'b0, err: 1'b1, cpur: 1'b1, wc: 16'd0};
         exp_st.push_back(s);
      end else begin
         for (int i = 0; i < int'(n); i++) begin
            exp_wr.push_back('{addr: BASE + 32'(i) * 32'd4, data: ld_words[i]});
            x = x ^ ld_words[i][7:0] ^ ld_words[i][15:8] ^ ld_words[i][23:16] ^ ld_words[i][31:24];
         end
         if (chk_flip == 8'h00) s = '{done: 1'b1, err: 1'b0, cpur: 1'b0, wc: n};
         else                   s = '{done: 1'b0, err: 1'b1, cpur: 1'b1, wc: n};
         exp_st.push_back(s);
      end
      do_start();
      send_byte(n[7:0], 0, 1'b0);
      send_byte(n[15:8], 0, 1'b0);
      if (32'(n) <= DEPTH) begin
         for (int i = 0; i < int'(n); i++) begin
            logic [31:0] w;
            w = ld_words[i];
            for (int k = 0; k < 4; k++)
               send_byte(w[8*k +: 8], (max_gap > 0) ? $urandom_range(max_gap, 1) : 0, poke);
         end
         send_byte(x ^ chk_flip, 0, 1'b0);
      end
      @(negedge clk);
      byte_valid = 1'b0;
      drain();
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
      repeat (3) @(negedge clk);
      start = 1'b1; byte_valid = 1'b1;
      @(negedge clk);
      check("rst_ready", {31'b0, byte_ready}, 32'd0);
      check("rst_cpu_reset", {31'b0, cpu_reset}, 32'd1);
      check("rst_done", {31'b0, load_done}, 32'd0);
      check("rst_error", {31'b0, error}, 32'd0);
      check("rst_we", {31'b0, imem_we}, 32'd0);
      check("rst_addr", imem_addr, BASE);
      check("rst_wdata", imem_wdata, 32'd0);
      check("rst_word_count", {16'b0, word_count}, 32'd0);
      start = 1'b0; byte_valid = 1'b0;
      reset = 1'b0;

      ld_words = '{32'h00500093, 32'h00A00113};
      run_load(16'd2, 8'h00, 0, 1'b0);
      run_load(16'd2, 8'h01, 0, 1'b0);
      ld_words = {};
      run_load(16'd257, 8'h00, 0, 1'b0);
      run_load(16'd0, 8'h00, 0, 1'b0);
      ld_words = '{32'h00500093, 32'h00A00113};
      run_load(16'd2, 8'h00, 5, 1'b1);

      // Abort mid-load after six payload bytes: only the first word lands.
      exp_wr.push_back('{addr: BASE, data: 32'h00500093});
      do_start();
      send_byte(8'h02, 0, 1'b0);
      send_byte(8'h00, 0, 1'b0);
      send_byte(8'h93, 0, 1'b0); send_byte(8'h00, 0, 1'b0);
      send_byte(8'h50, 0, 1'b0); send_byte(8'h00, 0, 1'b0);
      send_byte(8'h13, 1, 1'b0); send_byte(8'h01, 0, 1'b0);
      @(negedge clk);
      byte_valid = 1'b0;
      reset      = 1'b1;
      @(negedge clk);
      check("abort_ready", {31'b0, byte_ready}, 32'd0);
      check("abort_cpu_reset", {31'b0, cpu_reset}, 32'd1);
      check("abort_word_count", {16'b0, word_count}, 32'd0);
      check("abort_addr", imem_addr, BASE);
      reset = 1'b0;
      drain();
      run_load(16'd2, 8'h00, 0, 1'b0);

      for (int r = 0; r < 8; r++) begin
         int unsigned n;
         logic [7:0]  flip;
         n = $urandom_range(6, 1);
         ld_words = {};
         for (int i = 0; i < int'(n); i++) ld_words.push_back($urandom);
         flip = ($urandom_range(2, 0) == 0) ? 8'($urandom_range(255, 1)) : 8'h00;
         run_load(16'(n), flip, $urandom_range(3, 0), 1'($urandom_range(1, 0)));
      end

      ld_words = {};
      for (int i = 0; i < int'(DEPTH); i++) ld_words.push_back($urandom);
      run_load(16'(DEPTH), 8'h00, 0, 1'b0);

      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end

endmodule
